// File: rtl/mips_defs_pkg.sv
// Shared encodings for the multicycle MIPS-lite controller: opcodes, functs,
// FSM states and the datapath select codes.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DCD    = 4'd1,
        EXE    = 4'd2,
        WB_ALU = 4'd3,
        MA     = 4'd4,
        MEM_RD = 4'd5,
        MEM_WR = 4'd6,
        WB_MEM = 4'd7,
        BR     = 4'd8
    } state_t;

    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] REG_DST_RA = 2'd2;

    localparam logic [1:0] WD_ALU  = 2'd0;
    localparam logic [1:0] WD_DM   = 2'd1;
    localparam logic [1:0] WD_LINK = 2'd2;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_OR  = 2'd2;

    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_LUI  = 2'd2;

    localparam logic [1:0] NPC_SEQ = 2'd0;
    localparam logic [1:0] NPC_BR  = 2'd1;
    localparam logic [1:0] NPC_JMP = 2'd2;
    localparam logic [1:0] NPC_REG = 2'd3;

    // One-hot instruction class produced by mc_decode.
    typedef struct packed {
        logic rtype_alu;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic jr;
        logic illegal;
    } iclass_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction classifier: one-hot class plus the register-file
// destination index that the class writes (rd, rt or 31).
module mc_decode
    import mips_defs::*;
(
    input  logic [31:0] instr,
    output iclass_t     iclass,
    output logic [4:0]  dst
);

    logic [5:0] op;
    logic [5:0] fn;
    logic       unused_fields;

    assign op = instr[31:26];
    assign fn = instr[5:0];
    // rs and shamt never influence control.
    assign unused_fields = ^{instr[25:21], instr[10:6]};

    always_comb begin
        iclass = '0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADDU, FN_SUBU: iclass.rtype_alu = 1'b1;
                    FN_JR:            iclass.jr        = 1'b1;
                    default:          iclass.illegal   = 1'b1;
                endcase
            end
            OP_ORI:  iclass.ori     = 1'b1;
            OP_LUI:  iclass.lui     = 1'b1;
            OP_LW:   iclass.lw      = 1'b1;
            OP_SW:   iclass.sw      = 1'b1;
            OP_BEQ:  iclass.beq     = 1'b1;
            OP_J:    iclass.j       = 1'b1;
            OP_JAL:  iclass.jal     = 1'b1;
            default: iclass.illegal = 1'b1;
        endcase
    end

    always_comb begin
        dst = instr[20:16];
        if (iclass.jal)
            dst = 5'd31;
        else if (iclass.rtype_alu)
            dst = instr[15:11];
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle control FSM for the MIPS-lite datapath; owns every write enable
// and mux select, sequencing each instruction over 2-5 cycles.
module mc_ctrl
    import mips_defs::*;
#(
    parameter int RST_PC_HOLD = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic        pc_we,
    output logic        ir_we,
    output logic        gpr_we,
    output logic        dm_we,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wd_sel,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic [1:0]  ext_op,
    output logic [1:0]  npc_sel,
    output logic        instr_done,
    output logic [3:0]  state
);

    state_t     state_q;
    state_t     state_nxt;
    logic       hold_q;
    iclass_t    ic;
    logic [4:0] dst;
    logic       gpr_we_raw;
    logic       is_subu;

    mc_decode u_decode (
        .instr  (instr),
        .iclass (ic),
        .dst    (dst)
    );

    assign is_subu = (instr[5:0] == FN_SUBU);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            hold_q  <= (RST_PC_HOLD != 0);
        end else begin
            state_q <= state_nxt;
            hold_q  <= 1'b0;
        end
    end

    assign state = rst ? FETCH : state_q;

    always_comb begin
        state_nxt  = FETCH;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        gpr_we_raw = 1'b0;
        dm_we      = 1'b0;
        reg_dst    = REG_DST_RT;
        wd_sel     = WD_ALU;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        ext_op     = EXT_ZERO;
        npc_sel    = NPC_SEQ;
        instr_done = 1'b0;
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    // Post-reset settle cycle: no fetch, stay put once.
                    if (hold_q) begin
                        state_nxt = FETCH;
                    end else begin
                        ir_we     = 1'b1;
                        pc_we     = 1'b1;
                        state_nxt = DCD;
                    end
                end
                DCD: begin
                    if (ic.rtype_alu || ic.ori || ic.lui) begin
                        state_nxt = EXE;
                    end else if (ic.lw || ic.sw) begin
                        state_nxt = MA;
                    end else if (ic.beq) begin
                        state_nxt = BR;
                    end else if (ic.j) begin
                        pc_we      = 1'b1;
                        npc_sel    = NPC_JMP;
                        instr_done = 1'b1;
                    end else if (ic.jal) begin
                        pc_we      = 1'b1;
                        npc_sel    = NPC_JMP;
                        gpr_we_raw = 1'b1;
                        reg_dst    = REG_DST_RA;
                        wd_sel     = WD_LINK;
                        instr_done = 1'b1;
                    end else if (ic.jr) begin
                        pc_we      = 1'b1;
                        npc_sel    = NPC_REG;
                        instr_done = 1'b1;
                    end else begin
                        instr_done = 1'b1;
                    end
                end
                EXE, WB_ALU: begin
                    if (ic.rtype_alu) begin
                        alu_op = is_subu ? ALU_SUB : ALU_ADD;
                    end else if (ic.ori) begin
                        alu_src = 1'b1;
                        ext_op  = EXT_ZERO;
                        alu_op  = ALU_OR;
                    end else if (ic.lui) begin
                        alu_src = 1'b1;
                        ext_op  = EXT_LUI;
                        alu_op  = ALU_OR;
                    end
                    if (state_q == EXE) begin
                        state_nxt = WB_ALU;
                    end else begin
                        gpr_we_raw = 1'b1;
                        wd_sel     = WD_ALU;
                        reg_dst    = ic.rtype_alu ? REG_DST_RD : REG_DST_RT;
                        instr_done = 1'b1;
                    end
                end
                MA, MEM_RD, MEM_WR: begin
                    alu_src = 1'b1;
                    ext_op  = EXT_SIGN;
                    alu_op  = ALU_ADD;
                    if (state_q == MA) begin
                        state_nxt = ic.lw ? MEM_RD : MEM_WR;
                    end else if (state_q == MEM_RD) begin
                        state_nxt = WB_MEM;
                    end else begin
                        dm_we      = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                WB_MEM: begin
                    gpr_we_raw = 1'b1;
                    wd_sel     = WD_DM;
                    reg_dst    = REG_DST_RT;
                    instr_done = 1'b1;
                end
                BR: begin
                    alu_src    = 1'b0;
                    alu_op     = ALU_SUB;
                    ext_op     = EXT_SIGN;
                    npc_sel    = NPC_BR;
                    pc_we      = zero;
                    instr_done = 1'b1;
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

    // $0 is hardwired: never write index 0 whatever the instruction says.
    assign gpr_we = gpr_we_raw && (dst != 5'd0);

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle expected control vectors are queued
// by hand and compared against the DUT outputs one cycle at a time.
module tb_mc_ctrl;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DCD    = 4'd1;
    localparam logic [3:0] S_EXE    = 4'd2;
    localparam logic [3:0] S_WB_ALU = 4'd3;
    localparam logic [3:0] S_MA     = 4'd4;
    localparam logic [3:0] S_MEM_RD = 4'd5;
    localparam logic [3:0] S_MEM_WR = 4'd6;
    localparam logic [3:0] S_WB_MEM = 4'd7;
    localparam logic [3:0] S_BR     = 4'd8;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        zero;

    logic        pc_we, ir_we, gpr_we, dm_we, alu_src, instr_done;
    logic [1:0]  reg_dst, wd_sel, alu_op, ext_op, npc_sel;
    logic [3:0]  state;

    logic        h_pc_we, h_ir_we, h_gpr_we, h_dm_we, h_alu_src, h_instr_done;
    logic [1:0]  h_reg_dst, h_wd_sel, h_alu_op, h_ext_op, h_npc_sel;
    logic [3:0]  h_state;

    logic [19:0] obs;
    logic [19:0] h_obs;
    logic [19:0] exp_q[$];
    int          n_chk;
    int          n_pass;
    logic        hold_done;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero),
        .pc_we(pc_we), .ir_we(ir_we), .gpr_we(gpr_we), .dm_we(dm_we),
        .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_src(alu_src),
        .alu_op(alu_op), .ext_op(ext_op), .npc_sel(npc_sel),
        .instr_done(instr_done), .state(state)
    );

    mc_ctrl #(.RST_PC_HOLD(1)) dut_h (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero),
        .pc_we(h_pc_we), .ir_we(h_ir_we), .gpr_we(h_gpr_we), .dm_we(h_dm_we),
        .reg_dst(h_reg_dst), .wd_sel(h_wd_sel), .alu_src(h_alu_src),
        .alu_op(h_alu_op), .ext_op(h_ext_op), .npc_sel(h_npc_sel),
        .instr_done(h_instr_done), .state(h_state)
    );

    assign obs = {pc_we, ir_we, gpr_we, dm_we, reg_dst, wd_sel, alu_src,
                  alu_op, ext_op, npc_sel, instr_done, state};
    assign h_obs = {h_pc_we, h_ir_we, h_gpr_we, h_dm_we, h_reg_dst, h_wd_sel,
                    h_alu_src, h_alu_op, h_ext_op, h_npc_sel, h_instr_done, h_state};

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [19:0] v(
        input logic pc, input logic ir, input logic gpr, input logic dm,
        input logic [1:0] rdst, input logic [1:0] wd, input logic src,
        input logic [1:0] op, input logic [1:0] ext, input logic [1:0] npc,
        input logic done, input logic [3:0] st
    );
        return {pc, ir, gpr, dm, rdst, wd, src, op, ext, npc, done, st};
    endfunction

    task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %05h expected %05h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic drive(input logic [31:0] i, input logic z);
        instr = i;
        zero  = z;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks every queued vector, one per cycle, ending on the last state.
    task automatic drain(input string tag);
        int k;
        k = 0;
        while (exp_q.size() > 0) begin
            if (k > 0) step();
            check($sformatf("%s_c%0d", tag, k), obs, exp_q.pop_front());
            k++;
        end
    endtask

    task automatic push_fetch_dcd();
        exp_q.push_back(v(1,1,0,0, 0,0,0, 0,0,0, 0, S_FETCH));
        exp_q.push_back(v(0,0,0,0, 0,0,0, 0,0,0, 0, S_DCD));
    endtask

    // Hold-variant DUT: one idle FETCH after reset release, then a real fetch.
    initial begin
        hold_done = 1'b0;
        @(negedge rst);
        check("hold_idle_fetch", h_obs, v(0,0,0,0, 0,0,0, 0,0,0, 0, S_FETCH));
        step();
        check("hold_real_fetch", h_obs, v(1,1,0,0, 0,0,0, 0,0,0, 0, S_FETCH));
        step();
        check("hold_dcd", h_obs, v(0,0,0,0, 0,0,0, 0,0,0, 0, S_DCD));
        hold_done = 1'b1;
    end

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b1;
        drive(32'h0000_0000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", obs, 20'h0);
        rst = 1'b0;
        #1;

        // addu $3,$1,$2
        drive(32'h0022_1821, 1'b0);
        push_fetch_dcd();
        exp_q.push_back(v(0,0,0,0, 0,0,0, 0,0,0, 0, S_EXE));
        exp_q.push_back(v(0,0,1,0, 1,0,0, 0,0,0, 1, S_WB_ALU));
        drain("addu");
        step();

        // subu $3,$1,$2
        drive(32'h0022_1823, 1'b0);
        push_fetch_dcd();
        exp_q.push_back(v(0,0,0,0, 0,0,0, 1,0,0, 0, S_EXE));
        exp_q.push_back(v(0,0,1,0, 1,0,0, 1,0,0, 1, S_WB_ALU));
        drain("subu");
        step();

        // addu $0,$1,$2: rd=0 must not be written
        drive(32'h0022_0021, 1'b0);
        push_fetch_dcd();
        exp_q.push_back(v(0,0,0,0, 0,0,0, 0,0,0, 0, S_EXE));
        exp_q.push_back(v(0,0,0,0, 1,0,0, 0,0,0, 1, S_WB_ALU));
        drain("addu_r0");
        step();

        // lw $4,8($0)
        drive(32'h8C04_0008, 1'b0);
        push_fetch_dcd();
        exp_q.push_back(v(0,0,0,0, 0,0,1, 0,1,0, 0, S_MA));
        exp_q.push_back(v(0,0,0,0, 0,0,1, 0,1,0, 0, S_MEM_RD));
        exp_q.push_back(v(0,0,1,0, 0,1,0, 0,0,0, 1, S_WB_MEM));
        drain("lw");
        step();

        // sw $4,8($0)
        drive(32'hAC04_0008, 1'b0);
        push_fetch_dcd();
        exp_q.push_back(v(0,0,0,0, 0,0,1, 0,1,0, 0, S_MA));
        exp_q.push_back(v(0,0,0,1, 0,0,1, 0,1,0, 1, S_MEM_WR));
        drain("sw");
        step();

        // beq taken / not taken
        drive(32'h1022_0004, 1'b1);
        push_fetch_dcd();
        exp_q.push_back(v(1,0,0,0, 0,0,0, 1,1,1, 1, S_BR));
        drain("beq_t");
        step();
        drive(32'h1022_0004, 1'b0);
        push_fetch_dcd();
        exp_q.push_back(v(0,0,0,0, 0,0,0, 1,1,1, 1, S_BR));
        drain("beq_nt");
        step();

        // jal, jr $31, j
        drive(32'h0C00_0100, 1'b0);
        exp_q.push_back(v(1,1,0,0, 0,0,0, 0,0,0, 0, S_FETCH));
        exp_q.push_back(v(1,0,1,0, 2,2,0, 0,0,2, 1, S_DCD));
        drain("jal");
        step();
        drive(32'h03E0_0008, 1'b0);
        exp_q.push_back(v(1,1,0,0, 0,0,0, 0,0,0, 0, S_FETCH));
        exp_q.push_back(v(1,0,0,0, 0,0,0, 0,0,3, 1, S_DCD));
        drain("jr");
        step();
        drive(32'h0800_0040, 1'b0);
        exp_q.push_back(v(1,1,0,0, 0,0,0, 0,0,0, 0, S_FETCH));
        exp_q.push_back(v(1,0,0,0, 0,0,0, 0,0,2, 1, S_DCD));
        drain("j");
        step();

        // ori $0,$1,5 (suppressed) and ori $5,$1,7
        drive(32'h3420_0005, 1'b0);
        push_fetch_dcd();
        exp_q.push_back(v(0,0,0,0, 0,0,1, 2,0,0, 0, S_EXE));
        exp_q.push_back(v(0,0,0,0, 0,0,1, 2,0,0, 1, S_WB_ALU));
        drain("ori_r0");
        step();
        drive(32'h3425_0007, 1'b0);
        push_fetch_dcd();
        exp_q.push_back(v(0,0,0,0, 0,0,1, 2,0,0, 0, S_EXE));
        exp_q.push_back(v(0,0,1,0, 0,0,1, 2,0,0, 1, S_WB_ALU));
        drain("ori");
        step();

        // lui $6,0x1234
        drive(32'h3C06_1234, 1'b0);
        push_fetch_dcd();
        exp_q.push_back(v(0,0,0,0, 0,0,1, 2,2,0, 0, S_EXE));
        exp_q.push_back(v(0,0,1,0, 0,0,1, 2,2,0, 1, S_WB_ALU));
        drain("lui");
        step();

        // Unknown opcode and unknown R funct: 2-cycle nop
        drive(32'hFC00_0000, 1'b0);
        exp_q.push_back(v(1,1,0,0, 0,0,0, 0,0,0, 0, S_FETCH));
        exp_q.push_back(v(0,0,0,0, 0,0,0, 0,0,0, 1, S_DCD));
        drain("nop_op");
        step();
        drive(32'h0022_182A, 1'b0);
        exp_q.push_back(v(1,1,0,0, 0,0,0, 0,0,0, 0, S_FETCH));
        exp_q.push_back(v(0,0,0,0, 0,0,0, 0,0,0, 1, S_DCD));
        drain("nop_fn");
        step();

        // Reset for 2 cycles while lw sits in MEM_RD
        drive(32'h8C04_0008, 1'b0);
        push_fetch_dcd();
        exp_q.push_back(v(0,0,0,0, 0,0,1, 0,1,0, 0, S_MA));
        exp_q.push_back(v(0,0,0,0, 0,0,1, 0,1,0, 0, S_MEM_RD));
        drain("lw_abort");
        rst = 1'b1;
        #1;
        check("abort_rst_comb", obs, 20'h0);
        step();
        check("abort_rst_c1", obs, 20'h0);
        step();
        check("abort_rst_c2", obs, 20'h0);
        rst = 1'b0;
        #1;
        check("abort_refetch", obs, v(1,1,0,0, 0,0,0, 0,0,0, 0, S_FETCH));
        step();
        check("abort_dcd", obs, v(0,0,0,0, 0,0,0, 0,0,0, 0, S_DCD));

        repeat (2) step();
        if (!hold_done) check("hold_timeout", {19'h0, hold_done}, 20'h1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
